// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT frame feeder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fft_pkg;

    localparam int W_DEF     = 11;
    localparam int LOG2N_DEF = 6;
    localparam int IDX_MAX_W = 16;   // widest index bitrev_idx can handle

    typedef struct packed {
        logic signed [W_DEF-1:0] re;
        logic signed [W_DEF-1:0] im;
    } cplx_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    // Reverses the low n bits of v; bits at and above n come back zero.
    // Shifting keeps every bit select at a constant position.
    function automatic logic [IDX_MAX_W-1:0] bitrev_idx(input logic [IDX_MAX_W-1:0] v,
                                                       input int n);
        logic [IDX_MAX_W-1:0] src;
        logic [IDX_MAX_W-1:0] res;
        src = v;
        res = '0;
        for (int i = 0; i < IDX_MAX_W; i++) begin
            if (i < n) begin
                res = {res[IDX_MAX_W-2:0], src[0]};
                src = src >> 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_feed_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
// Latency: read data appears one cycle after an enabled read; write is immediate.
// Backpressure: none; holding re low freezes rdata.
// Ports: clk/rst, we/waddr/wdata (write), re/raddr (read request), rdata (registered).
module fft_feed_ram #(
    parameter int AW = 7,
    parameter int DW = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register doubles as the feeder's output data register, so it resets
    // to zero and only updates when a new word is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer: collects N complex samples per bank, replays each full bank as a burst.
// Latency: last sample accepted at edge k -> out_valid/out_sof after edge k+2 (reader idle).
// Backpressure: out_ready=0 freezes the output word; input samples arriving at a full bank are dropped (ovf).
// Ports: clk/rst; in_valid/in_re/in_im sample in; bitrev selects readout order of the next frame;
//        out_valid/out_ready handshake with out_re/out_im/out_idx/out_sof/out_eof; ovf pulse, ovf_cnt count.
module fft_frame_feeder
    import fft_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LOG2N = LOG2N_DEF,
    parameter int OVF_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     in_re,
    input  logic [W-1:0]     in_im,
    input  logic             bitrev,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_re,
    output logic [W-1:0]     out_im,
    output logic [LOG2N-1:0] out_idx,
    output logic             out_sof,
    output logic             out_eof,
    output logic             ovf,
    output logic [OVF_W-1:0] ovf_cnt
);

    logic [1:0]       full;
    logic             wr_bank;
    logic [LOG2N-1:0] wr_idx;
    logic             rd_bank;
    logic [LOG2N:0]   rd_idx;     // extra MSB marks "all N addresses issued"
    logic             mode;
    rd_state_t        state;
    rd_state_t        state_nxt;
    logic             rd_start;
    logic             rd_issue;
    logic             rd_done;
    logic             wr_acc;
    logic [LOG2N-1:0] rd_addr;
    logic [2*W-1:0]   rd_dat;

    // Last word of the frame leaves the output register this edge.
    assign rd_done  = (state == RD_READ) && rd_idx[LOG2N] && out_valid && out_ready;
    // Issue a new RAM read when the output register is empty or being consumed.
    assign rd_issue = (state == RD_READ) && !rd_idx[LOG2N] && (!out_valid || out_ready);
    // A bank being released this very edge is writable (clear wins over overflow).
    assign wr_acc   = in_valid && (!full[wr_bank] || (rd_done && (rd_bank == wr_bank)));

    assign rd_addr = mode ? LOG2N'(bitrev_idx(16'(rd_idx[LOG2N-1:0]), LOG2N))
                          : rd_idx[LOG2N-1:0];

    always_comb begin
        state_nxt = state;
        rd_start  = 1'b0;
        case (state)
            RD_IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt = RD_READ;
                    rd_start  = 1'b1;
                end
            end
            RD_READ: begin
                if (rd_done) begin
                    state_nxt = RD_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RD_IDLE;
            full      <= '0;
            wr_bank   <= 1'b0;
            wr_idx    <= '0;
            rd_bank   <= 1'b0;
            rd_idx    <= '0;
            mode      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            ovf       <= 1'b0;
            ovf_cnt   <= '0;
        end else begin
            state <= state_nxt;

            if (rd_start) begin
                mode   <= bitrev;
                rd_idx <= '0;
            end else if (rd_issue) begin
                rd_idx <= rd_idx + 1'b1;
            end

            if (rd_issue) begin
                out_valid <= 1'b1;
                out_idx   <= rd_addr;
                out_sof   <= (rd_idx == '0);
                out_eof   <= (rd_idx[LOG2N-1:0] == '1);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
                out_eof   <= 1'b0;
            end

            if (rd_done) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end

            // Placed after the clear so a completing writer would win on the same bank.
            if (wr_acc) begin
                wr_idx <= wr_idx + 1'b1;
                if (wr_idx == '1) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end

            ovf <= in_valid && !wr_acc;
            if (in_valid && !wr_acc && (ovf_cnt != '1)) begin
                ovf_cnt <= ovf_cnt + 1'b1;
            end
        end
    end

    fft_feed_ram #(
        .AW (LOG2N + 1),
        .DW (2 * W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr ({wr_bank, wr_idx}),
        .wdata ({in_re, in_im}),
        .re    (rd_issue),
        .raddr ({rd_bank, rd_addr}),
        .rdata (rd_dat)
    );

    assign out_re = rd_dat[2*W-1:W];
    assign out_im = rd_dat[W-1:0];

endmodule

// File: tb/tb_fft_frame_feeder.sv
module tb_fft_frame_feeder;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [10:0] in_re;
    logic signed [10:0] in_im;
    logic               bitrev;
    logic               out_ready;
    logic               out_valid;
    logic signed [10:0] out_re;
    logic signed [10:0] out_im;
    logic [5:0]         out_idx;
    logic               out_sof;
    logic               out_eof;
    logic               ovf;
    logic [15:0]        ovf_cnt;

    always #5 clk = ~clk;

    fft_frame_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .bitrev    (bitrev),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .ovf       (ovf),
        .ovf_cnt   (ovf_cnt)
    );

    typedef struct {
        int re;
        int im;
        int idx;
        int sof;
        int eof;
        int cyc;
    } cap_t;

    // One table row = one frame: order, ready pattern, sample base, expected sof->eof span.
    typedef struct {
        int br;
        int rmode;   // 0 ready high, 1 ready toggling, 2 ready low
        int base;
        int span;
    } vec_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rmode = 2;
    int   src_q[$];
    bit   src_en = 1'b0;
    cap_t cap_q[$];
    int   last_in_cyc = -1;
    int   first_in_cyc = -1;
    int   first_ovf_cyc = -1;
    int   ovf_seen = 0;
    bit   inject = 1'b0;
    int   inj_val = 0;
    bit   prev_stall = 1'b0;
    int   h_re, h_im, h_idx, h_sof, h_eof;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int rev6(input int k);
        int r = 0;
        for (int i = 0; i < 6; i++) r = (r << 1) | ((k >> i) & 1);
        return r;
    endfunction

    // One clock: outputs are sampled 1ns after the edge, then next inputs are driven.
    task automatic cycle();
        bit inj_now;
        @(posedge clk);
        #1;
        cyc++;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 2 == 0);
            default: out_ready = 1'b0;
        endcase
        if (prev_stall && !rst) begin
            check("hold_vld", int'(out_valid), 1);
            check("hold_re",  int'(out_re),  h_re);
            check("hold_im",  int'(out_im),  h_im);
            check("hold_idx", int'(out_idx), h_idx);
            check("hold_sof", int'(out_sof), h_sof);
            check("hold_eof", int'(out_eof), h_eof);
        end
        prev_stall = out_valid && !out_ready && !rst;
        h_re = int'(out_re); h_im = int'(out_im); h_idx = int'(out_idx);
        h_sof = int'(out_sof); h_eof = int'(out_eof);
        inj_now = 1'b0;
        if (out_valid && out_ready && !rst) begin
            cap_q.push_back('{int'(out_re), int'(out_im), int'(out_idx),
                              int'(out_sof), int'(out_eof), cyc});
            if (inject && out_eof) begin
                inject  = 1'b0;
                inj_now = 1'b1;
            end
        end
        if (ovf) begin
            ovf_seen++;
            if (first_ovf_cyc < 0) first_ovf_cyc = cyc;
        end
        if (inj_now) begin
            in_valid = 1'b1;
            in_re = 11'(inj_val);
            in_im = 11'(-inj_val);
            src_en = 1'b1;
            last_in_cyc = cyc;
        end else if (src_en && src_q.size() > 0) begin
            in_valid = 1'b1;
            in_re = 11'(src_q[0]);
            in_im = 11'(-src_q[0]);
            void'(src_q.pop_front());
            if (first_in_cyc < 0) first_in_cyc = cyc;
            last_in_cyc = cyc;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        rmode = 2;
        src_q.delete();
        src_en = 1'b0;
        inject = 1'b0;
        prev_stall = 1'b0;
        in_valid = 1'b0;
        bitrev = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        prev_stall = 1'b0;
        cap_q.delete();
        ovf_seen = 0;
        first_ovf_cyc = -1;
        first_in_cyc = -1;
        last_in_cyc = -1;
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{0, 0,    0,  63};
        vecs[1] = '{1, 0,    0,  63};
        vecs[2] = '{0, 1,  100, 126};
        vecs[3] = '{1, 1,  200, 126};
        vecs[4] = '{0, 0, -500,  63};

        rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;
        bitrev = 1'b0; out_ready = 1'b0;

        // Reset state
        reset_dut();
        check("rst_vld", int'(out_valid), 0);
        check("rst_re",  int'(out_re), 0);
        check("rst_im",  int'(out_im), 0);
        check("rst_idx", int'(out_idx), 0);
        check("rst_sof", int'(out_sof), 0);
        check("rst_eof", int'(out_eof), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_ovfcnt", int'(ovf_cnt), 0);

        // Single frames from the table
        for (int vi = 0; vi < 5; vi++) begin
            reset_dut();
            bitrev = vecs[vi].br[0];
            rmode  = vecs[vi].rmode;
            for (int i = 0; i < 64; i++) src_q.push_back(vecs[vi].base + i);
            src_en = 1'b1;
            for (int t = 0; t < 400 && cap_q.size() < 64; t++) begin
                cycle();
                // Flipping the order request mid-frame must not disturb this frame.
                if (cap_q.size() > 0) bitrev = ~vecs[vi].br[0];
            end
            check($sformatf("v%0d_count", vi), cap_q.size(), 64);
            if (cap_q.size() == 64) begin
                for (int k = 0; k < 64; k++) begin
                    int e;
                    e = (vecs[vi].br != 0) ? rev6(k) : k;
                    check($sformatf("v%0d_w%0d_idx", vi, k), cap_q[k].idx, e);
                    check($sformatf("v%0d_w%0d_re",  vi, k), cap_q[k].re, vecs[vi].base + e);
                    check($sformatf("v%0d_w%0d_im",  vi, k), cap_q[k].im, -(vecs[vi].base + e));
                    check($sformatf("v%0d_w%0d_sof", vi, k), cap_q[k].sof, (k == 0) ? 1 : 0);
                    check($sformatf("v%0d_w%0d_eof", vi, k), cap_q[k].eof, (k == 63) ? 1 : 0);
                end
                check($sformatf("v%0d_span", vi), cap_q[63].cyc - cap_q[0].cyc, vecs[vi].span);
                // Last sample sampled at edge k, valid after edge k+2: third sampling slot after driving.
                if (vecs[vi].rmode == 0)
                    check($sformatf("v%0d_latency", vi), cap_q[0].cyc - last_in_cyc, 3);
            end
            check($sformatf("v%0d_ovfcnt", vi), int'(ovf_cnt), 0);
            check($sformatf("v%0d_ovfseen", vi), ovf_seen, 0);
        end

        // Overflow: 192 samples while the FFT stalls for 200 cycles
        reset_dut();
        rmode = 2;
        for (int i = 0; i < 192; i++) src_q.push_back(i);
        src_en = 1'b1;
        for (int t = 0; t < 200; t++) cycle();
        check("ovf_cnt", int'(ovf_cnt), 64);
        check("ovf_pulses", ovf_seen, 64);
        check("ovf_first", first_ovf_cyc - first_in_cyc, 129);
        check("ovf_none_out", cap_q.size(), 0);
        rmode = 0;
        for (int t = 0; t < 400 && cap_q.size() < 128; t++) cycle();
        for (int t = 0; t < 20; t++) cycle();
        check("ovf_count_out", cap_q.size(), 128);
        if (cap_q.size() == 128) begin
            for (int k = 0; k < 128; k++)
                check($sformatf("ovf_w%0d_re", k), cap_q[k].re, k);
            check("ovf_sof1", cap_q[64].sof, 1);
            check("ovf_eof0", cap_q[63].eof, 1);
            // One IDLE cycle plus the cycle that issues address 0 of the next frame.
            check("ovf_gap", cap_q[64].cyc - cap_q[63].cyc, 3);
        end

        // Reset mid-frame: partial frame discarded
        reset_dut();
        rmode = 0;
        for (int i = 0; i < 40; i++) src_q.push_back(300 + i);
        src_en = 1'b1;
        for (int t = 0; t < 42; t++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        prev_stall = 1'b0;
        check("mid_rst_none", cap_q.size(), 0);
        cap_q.delete();
        for (int i = 0; i < 64; i++) src_q.push_back(i);
        for (int t = 0; t < 300 && cap_q.size() < 64; t++) cycle();
        for (int t = 0; t < 40; t++) cycle();
        check("mid_rst_count", cap_q.size(), 64);
        if (cap_q.size() == 64) begin
            for (int k = 0; k < 64; k++)
                check($sformatf("mid_rst_w%0d_re", k), cap_q[k].re, k);
            check("mid_rst_latency", cap_q[0].cyc - last_in_cyc, 3);
        end
        check("mid_rst_ovfcnt", int'(ovf_cnt), 0);

        // Reader frees bank 0 in the same cycle the next frame's first sample targets it
        reset_dut();
        rmode = 2;
        for (int i = 0; i < 128; i++) src_q.push_back(i);
        src_en = 1'b1;
        for (int t = 0; t < 140; t++) cycle();
        src_en = 1'b0;
        for (int i = 0; i < 63; i++) src_q.push_back(78 + i);
        inj_val = 77;
        inject = 1'b1;
        rmode = 0;
        for (int t = 0; t < 400 && cap_q.size() < 192; t++) cycle();
        check("race_inject_done", int'(inject), 0);
        check("race_ovf", ovf_seen, 0);
        check("race_ovfcnt", int'(ovf_cnt), 0);
        check("race_count", cap_q.size(), 192);
        if (cap_q.size() == 192) begin
            for (int k = 0; k < 192; k++)
                check($sformatf("race_w%0d_re", k), cap_q[k].re, (k < 128) ? k : 77 + (k - 128));
            check("race_sof2", cap_q[128].sof, 1);
            check("race_eof2", cap_q[191].eof, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
